// File: rtl/case9_pipe.sv
// Two-stage valid/ready pipeline evaluating a 10-input boolean cell per lane,
// followed by a saturating windowed accumulator of the per-lane term counts.
module case9_pipe #(
  parameter int LANES  = 1,
  parameter int ACC_W  = 16,
  parameter int WINDOW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [10*LANES-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_y1,
  output logic [LANES-1:0]     out_y2,
  output logic [3*LANES-1:0]   out_cnt,
  input  logic                 clr,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 acc_valid
);

  localparam int SUM_W = $clog2(5*LANES + 1);
  localparam int TOT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);
  localparam logic [TOT_W-1:0] ACC_MAX  = {{(TOT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  function automatic logic [2:0] pop5(input logic [4:0] v);
    pop5 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]} + {2'b00, v[4]};
  endfunction

  // Result packed as {y1, y2, cnt[2:0]}; input bit 0 is 'a', bit 9 is 'j'.
  function automatic logic [4:0] lane_eval(input logic [9:0] d);
    logic p, q, r, y1, y2;
    p  = (d[0] & d[1]) | ~(d[2] | d[3]);
    q  = (d[4] ^ d[5]) & d[6] & d[7];
    r  = d[8] | d[9];
    y1 = q & p;
    y2 = q | (r ^ p);
    lane_eval = {y1, y2, pop5({p, q, r, y1, y2})};
  endfunction

  logic                  s1_valid_r;
  logic [10*LANES-1:0]   s1_data_r;
  logic                  s2_load_s;
  logic                  s1_load_s;
  logic                  xfer_s;
  logic [LANES-1:0]      y1_nxt_s;
  logic [LANES-1:0]      y2_nxt_s;
  logic [3*LANES-1:0]    cnt_nxt_s;
  logic [SUM_W-1:0]      sum_s;
  logic [TOT_W-1:0]      tot_s;
  logic [ACC_W-1:0]      sat_s;
  logic [ACC_W-1:0]      acc_r;
  logic [15:0]           wcnt_r;

  assign s2_load_s = ~out_valid | out_ready;
  assign s1_load_s = ~s1_valid_r | s2_load_s;
  assign in_ready  = s1_load_s;
  assign xfer_s    = out_valid & out_ready;

  // Per-lane evaluation of the word held in S1.
  always_comb begin
    y1_nxt_s  = '0;
    y2_nxt_s  = '0;
    cnt_nxt_s = '0;
    for (int k = 0; k < LANES; k++) begin
      logic [4:0] res;
      if (s1_valid_r) begin
        res = lane_eval(s1_data_r[10*k +: 10]);
      end else begin
        res = 5'd0;
      end
      y1_nxt_s[k]        = res[4];
      y2_nxt_s[k]        = res[3];
      cnt_nxt_s[3*k +: 3] = res[2:0];
    end
  end

  // Sum of the lane counts currently presented, and the saturated running total.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_s = sum_s + SUM_W'(out_cnt[3*k +: 3]);
    end
    tot_s = TOT_W'(acc_r) + TOT_W'(sum_s);
    if (tot_s > ACC_MAX) begin
      sat_s = ACC_MAX[ACC_W-1:0];
    end else begin
      sat_s = tot_s[ACC_W-1:0];
    end
  end

  // Pipeline registers: S1 captures input, S2 drives the output ports directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      out_valid  <= 1'b0;
      out_y1     <= '0;
      out_y2     <= '0;
      out_cnt    <= '0;
    end else begin
      if (s1_load_s) begin
        s1_valid_r <= in_valid;
        if (in_valid) begin
          s1_data_r <= in_data;
        end
      end
      if (s2_load_s) begin
        out_valid <= s1_valid_r;
        out_y1    <= y1_nxt_s;
        out_y2    <= y2_nxt_s;
        out_cnt   <= cnt_nxt_s;
      end
    end
  end

  // Window accumulator; clr overrides a coincident output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      wcnt_r    <= 16'd0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (clr) begin
        acc_r  <= '0;
        wcnt_r <= 16'd0;
      end else if (xfer_s) begin
        if (wcnt_r == WIN_LAST) begin
          acc_out   <= sat_s;
          acc_valid <= 1'b1;
          acc_r     <= '0;
          wcnt_r    <= 16'd0;
        end else begin
          acc_r  <= sat_s;
          wcnt_r <= wcnt_r + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_case9_pipe.sv
// Directed bench for case9_pipe: a default instance, a WINDOW=1 twin sharing its
// inputs, and a LANES=3/ACC_W=4 instance for saturation and mid-flight reset.
module tb_case9_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, clr;
  logic [9:0]  in_data;
  logic        in_ready, out_valid, acc_valid;
  logic [0:0]  out_y1, out_y2;
  logic [2:0]  out_cnt;
  logic [15:0] acc_out;

  logic        w1_in_ready, w1_out_valid, w1_acc_valid;
  logic [0:0]  w1_out_y1, w1_out_y2;
  logic [2:0]  w1_out_cnt;
  logic [15:0] w1_acc_out;

  logic        s_rst_n, s_in_valid, s_out_ready, s_clr;
  logic [29:0] s_in_data;
  logic        s_in_ready, s_out_valid, s_acc_valid;
  logic [2:0]  s_out_y1, s_out_y2;
  logic [8:0]  s_out_cnt;
  logic [3:0]  s_acc_out;

  case9_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_y1(out_y1), .out_y2(out_y2),
    .out_cnt(out_cnt), .clr(clr), .acc_out(acc_out), .acc_valid(acc_valid));

  case9_pipe #(.WINDOW(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w1_in_ready), .in_data(in_data),
    .out_valid(w1_out_valid), .out_ready(out_ready), .out_y1(w1_out_y1), .out_y2(w1_out_y2),
    .out_cnt(w1_out_cnt), .clr(clr), .acc_out(w1_acc_out), .acc_valid(w1_acc_valid));

  case9_pipe #(.LANES(3), .ACC_W(4), .WINDOW(8)) u_sat (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_y1(s_out_y1), .out_y2(s_out_y2),
    .out_cnt(s_out_cnt), .clr(s_clr), .acc_out(s_acc_out), .acc_valid(s_acc_valid));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  localparam logic [9:0] W_ALL4 = 10'b0011010011;  // y1=1 y2=1 cnt=4

  // Feed n copies of d with out_ready=1; clr pulses with the clr_at-th output transfer.
  task automatic run_stream(input logic [9:0] d, input int n, input int clr_at,
                            output int pulses, output logic [15:0] last_acc,
                            output int w1_pulses, output logic [15:0] w1_last);
    int sent = 0;
    int ntx  = 0;
    pulses = 0; w1_pulses = 0; last_acc = 16'd0; w1_last = 16'd0;
    for (int c = 0; c < n + 10; c++) begin
      @(posedge clk); #1;
      if (acc_valid)    begin pulses++;    last_acc = acc_out;   end
      if (w1_acc_valid) begin w1_pulses++; w1_last = w1_acc_out; end
      in_valid  = (sent < n);
      in_data   = d;
      out_ready = 1'b1;
      #1;
      clr = 1'b0;
      if (out_valid && out_ready) begin
        ntx++;
        if (ntx == clr_at) clr = 1'b1;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  logic [9:0] words [5] = '{10'b0011010011, 10'b0000000000, 10'b1111111111,
                            10'b0000000100, 10'b0111010100};
  logic [4:0] exp5  [5] = '{5'b11100, 5'b01010, 5'b00010, 5'b00000, 5'b01011};

  initial begin
    int          p, wp, idx, n_out, stale;
    logic [15:0] la, wla;
    logic [4:0]  cur, prev;
    logic        have_prev, saw_low, first_seen;

    rst_n = 1'b1; s_rst_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; in_data = 10'd0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_clr = 1'b0; s_in_data = 30'd0;
    #2 rst_n = 1'b0; s_rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_y1",    out_y1,    1'b0);
    chk("rst_out_y2",    out_y2,    1'b0);
    chk("rst_out_cnt",   out_cnt,   3'd0);
    chk("rst_acc_out",   acc_out,   16'd0);
    chk("rst_acc_valid", acc_valid, 1'b0);

    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; s_rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1'b1);

    // Single word, two-cycle latency
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = W_ALL4; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat1_not_yet", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat2_valid", out_valid, 1'b1);
    chk("lat2_y1",    out_y1,    1'b1);
    chk("lat2_y2",    out_y2,    1'b1);
    chk("lat2_cnt",   out_cnt,   3'd4);
    @(posedge clk); #1;
    chk("single_no_dup",  out_valid,    1'b0);
    chk("w1_pulse",       w1_acc_valid, 1'b1);
    chk("w1_acc",         w1_acc_out,   16'd4);
    do_clr();

    // Eight zero words: cnt=2 each, one window of 16
    run_stream(10'd0, 8, 0, p, la, wp, wla);
    chk("win8_pulses", p,   32'd1);
    chk("win8_acc",    la,  16'd16);
    chk("w1_pulses",   wp,  32'd8);
    chk("w1_last",     wla, 16'd2);

    // Five words with a four-cycle output stall
    idx = 0; n_out = 0; have_prev = 1'b0; saw_low = 1'b0; prev = 5'd0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 3 && c < 7);
      in_valid  = (idx < 5);
      in_data   = (idx < 5) ? words[idx] : 10'd0;
      #1;
      if (!in_ready) saw_low = 1'b1;
      cur = {out_y1, out_y2, out_cnt};
      if (out_valid && !out_ready) begin
        if (have_prev) chk($sformatf("hold_c%0d", c), cur, prev);
        prev = cur; have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (n_out < 5) chk($sformatf("stream_out%0d", n_out), cur, exp5[n_out]);
        n_out++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    chk("stall_in_ready_low", saw_low, 1'b1);
    chk("stream_count",       n_out,   32'd5);
    chk("stream_all_sent",    idx,     32'd5);
    do_clr();

    // clr coincident with the 8th transfer suppresses the window
    run_stream(10'd0, 8, 8, p, la, wp, wla);
    chk("clr8_no_pulse", p,       32'd0);
    chk("clr8_acc_kept", acc_out, 16'd16);
    run_stream(W_ALL4, 8, 0, p, la, wp, wla);
    chk("clean_win_pulses", p,  32'd1);
    chk("clean_win_acc",    la, 16'd32);

    // LANES=3, ACC_W=4: 12 per transfer saturates at 15
    idx = 0; p = 0; la = 16'd0; first_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (s_acc_valid) begin p++; la = {12'd0, s_acc_out}; end
      s_in_valid = (idx < 8); s_in_data = {3{W_ALL4}}; s_out_ready = 1'b1;
      #1;
      if (s_out_valid && !first_seen) begin
        chk("sat_lane_cnt", s_out_cnt, 9'o444);
        first_seen = 1'b1;
      end
      if (s_in_valid && s_in_ready) idx++;
    end
    s_in_valid = 1'b0;
    chk("sat_pulses", p,  32'd1);
    chk("sat_acc",    la, 16'd15);

    // Reset with two words in flight
    s_out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      s_in_valid = 1'b1; s_in_data = 30'd0;
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    chk("inflight_valid",  s_out_valid, 1'b1);
    chk("inflight_full",   s_in_ready,  1'b0);
    s_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", s_out_valid, 1'b0);
    chk("async_rst_acc",   s_acc_out,   4'd0);
    @(posedge clk); #1;
    s_rst_n = 1'b1; s_out_ready = 1'b1;
    #1;
    chk("rst3_in_ready", s_in_ready, 1'b1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (s_out_valid) stale++;
    end
    chk("rst3_no_stale", stale,     32'd0);
    chk("rst3_acc_out",  s_acc_out, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
